// File: rtl/ext_packet_assembler_pkg.sv
// Shared types and helpers for the external-sensor packet assembler.
// Defines the packet record, the assembler state encoding and the timeout derivation.
package ext_pkt_pkg;

    typedef struct packed {
        logic [7:0] byte1;
        logic [7:0] byte2;
        logic       single;
    } ext_pkt_t;

    typedef enum logic {
        S_IDLE,
        S_WAIT_B2
    } asm_state_t;

    function automatic int unsigned timeout_cycles(input int unsigned clk_freq,
                                                   input int unsigned timeout_us);
        return (clk_freq / 1_000_000) * timeout_us;
    endfunction

endpackage

// File: rtl/ext_packet_assembler_if.sv
// Byte-receive strobe and packet valid/ready bundle for the packet assembler.
// The slave modport is the assembler side; the master modport is its environment.
interface ext_packet_assembler_if;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       pkt_ready;
    logic       pkt_valid;
    logic [7:0] pkt_byte1;
    logic [7:0] pkt_byte2;
    logic       pkt_single;

    modport master (
        output rx_dv, rx_byte, pkt_ready,
        input  pkt_valid, pkt_byte1, pkt_byte2, pkt_single
    );

    modport slave (
        input  rx_dv, rx_byte, pkt_ready,
        output pkt_valid, pkt_byte1, pkt_byte2, pkt_single
    );
endinterface

// File: rtl/ext_packet_assembler_fifo.sv
// Synchronous FIFO with extra-bit pointers; a push into a full FIFO is accepted
// only when a pop happens in the same cycle, otherwise it is ignored.
module pkt_fifo
    import ext_pkt_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = ext_pkt_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ext_packet_assembler.sv
// Groups received UART bytes into two-byte (or timeout-closed single-byte) sensor
// packets and buffers them behind a valid/ready interface.
module ext_packet_assembler
    import ext_pkt_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned TIMEOUT_US = 1000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    ext_packet_assembler_if.slave        bus,
    output logic                         busy,
    output logic                         overflow,
    output logic [7:0]                   drop_count
);
    localparam int unsigned TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ, TIMEOUT_US);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    asm_state_t       state;
    asm_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [7:0]       b1;
    logic [7:0]       b1_next;
    logic             push;
    ext_pkt_t         pkt_in;
    ext_pkt_t         head;
    ext_pkt_t         head_vis;
    logic             full;
    logic             empty;
    logic             pop;
    logic             drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            b1    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            b1    <= b1_next;
        end
    end

    // A byte arriving on the timeout cycle takes priority over the timeout.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        b1_next    = b1;
        push       = 1'b0;
        pkt_in     = '0;
        case (state)
            S_IDLE: begin
                if (bus.rx_dv) begin
                    b1_next    = bus.rx_byte;
                    cnt_next   = '0;
                    state_next = S_WAIT_B2;
                end
            end
            S_WAIT_B2: begin
                if (bus.rx_dv) begin
                    pkt_in     = '{byte1: b1, byte2: bus.rx_byte, single: 1'b0};
                    push       = 1'b1;
                    state_next = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    pkt_in     = '{byte1: b1, byte2: b1, single: 1'b1};
                    push       = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    pkt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (ext_pkt_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (pkt_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign pop  = !empty && bus.pkt_ready;
    assign drop = push && full && !pop;

    // Storage is not reset, so the head is masked to keep fields at zero when empty.
    assign head_vis       = empty ? '0 : head;
    assign bus.pkt_valid  = !empty;
    assign bus.pkt_byte1  = head_vis.byte1;
    assign bus.pkt_byte2  = head_vis.byte2;
    assign bus.pkt_single = head_vis.single;
    assign busy           = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_ext_packet_assembler.sv
// Directed bench for ext_packet_assembler: a vector table of two-byte packets plus
// hand-written timeout, overflow, full-with-pop and mid-packet reset sequences.
module tb_ext_packet_assembler;
    logic       clk;
    logic       rst;
    logic       busy;
    logic       overflow;
    logic [7:0] drop_count;
    int unsigned errors;
    int unsigned checks;

    ext_packet_assembler_if bus ();

    ext_packet_assembler #(
        .CLK_FREQ   (25_000_000),
        .TIMEOUT_US (1000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .busy       (busy),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    typedef struct {
        logic [7:0]  b1;
        logic [7:0]  b2;
        int unsigned gap;
        logic [7:0]  e1;
        logic [7:0]  e2;
        logic        es;
    } vec_t;

    vec_t vecs [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_dv   = 1'b1;
        bus.rx_byte = b;
        tick();
        bus.rx_dv   = 1'b0;
        bus.rx_byte = 8'h00;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_head(input string name, input logic [7:0] e1, input logic [7:0] e2,
                              input logic es);
        check({name, ".valid"},  32'(bus.pkt_valid),  32'd1);
        check({name, ".byte1"},  32'(bus.pkt_byte1),  32'(e1));
        check({name, ".byte2"},  32'(bus.pkt_byte2),  32'(e2));
        check({name, ".single"}, 32'(bus.pkt_single), 32'(es));
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".valid"},    32'(bus.pkt_valid),  32'd0);
        check({name, ".byte1"},    32'(bus.pkt_byte1),  32'd0);
        check({name, ".byte2"},    32'(bus.pkt_byte2),  32'd0);
        check({name, ".single"},   32'(bus.pkt_single), 32'd0);
        check({name, ".busy"},     32'(busy),           32'd0);
        check({name, ".overflow"}, 32'(overflow),       32'd0);
        check({name, ".drops"},    32'(drop_count),     32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        vecs[0] = '{b1: 8'h21, b2: 8'h5A, gap: 100, e1: 8'h21, e2: 8'h5A, es: 1'b0};
        vecs[1] = '{b1: 8'h00, b2: 8'hFF, gap: 0,   e1: 8'h00, e2: 8'hFF, es: 1'b0};
        vecs[2] = '{b1: 8'hFF, b2: 8'h00, gap: 1,   e1: 8'hFF, e2: 8'h00, es: 1'b0};
        vecs[3] = '{b1: 8'hA5, b2: 8'h3C, gap: 7,   e1: 8'hA5, e2: 8'h3C, es: 1'b0};

        rst           = 1'b1;
        bus.rx_dv     = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.pkt_ready = 1'b0;
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Two-byte packets drained immediately by the consumer.
        bus.pkt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_byte(vecs[i].b1);
            check($sformatf("v%0d.busy_after_b1", i), 32'(busy), 32'd1);
            idle(vecs[i].gap);
            check($sformatf("v%0d.busy_before_b2", i), 32'(busy), 32'd1);
            check($sformatf("v%0d.no_early_valid", i), 32'(bus.pkt_valid), 32'd0);
            send_byte(vecs[i].b2);
            check_head($sformatf("v%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].es);
            check($sformatf("v%0d.busy_after_b2", i), 32'(busy), 32'd0);
            tick();
            check($sformatf("v%0d.popped", i), 32'(bus.pkt_valid), 32'd0);
        end

        // Single byte closed by timeout after 25000 cycles in S_WAIT_B2.
        send_byte(8'h33);
        idle(24_999);
        check("timeout.not_yet_valid", 32'(bus.pkt_valid), 32'd0);
        check("timeout.still_busy", 32'(busy), 32'd1);
        tick();
        check_head("timeout", 8'h33, 8'h33, 1'b1);
        check("timeout.busy_cleared", 32'(busy), 32'd0);
        tick();
        check("timeout.popped", 32'(bus.pkt_valid), 32'd0);

        // Second byte lands on the timeout cycle and wins.
        send_byte(8'h44);
        idle(24_999);
        check("race.not_yet_valid", 32'(bus.pkt_valid), 32'd0);
        send_byte(8'h07);
        check_head("race", 8'h44, 8'h07, 1'b0);
        tick();
        check("race.popped", 32'(bus.pkt_valid), 32'd0);
        idle(5);
        check("race.no_single", 32'(bus.pkt_valid), 32'd0);
        check("race.idle", 32'(busy), 32'd0);

        // Overflow: three packets into a two-entry FIFO with no consumer.
        bus.pkt_ready = 1'b0;
        send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05); send_byte(8'h06);
        check("ovf.overflow", 32'(overflow), 32'd1);
        check("ovf.drops", 32'(drop_count), 32'd1);
        check_head("ovf.head0", 8'h01, 8'h02, 1'b0);
        idle(3);
        check_head("ovf.head0_stable", 8'h01, 8'h02, 1'b0);
        bus.pkt_ready = 1'b1;
        tick();
        check_head("ovf.head1", 8'h03, 8'h04, 1'b0);
        tick();
        check("ovf.drained", 32'(bus.pkt_valid), 32'd0);
        check("ovf.drops_sticky", 32'(drop_count), 32'd1);
        check("ovf.overflow_sticky", 32'(overflow), 32'd1);

        // Reset one cycle after a first byte, with one packet buffered.
        bus.pkt_ready = 1'b0;
        send_byte(8'h21); send_byte(8'h22);
        send_byte(8'h55);
        check("rst.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rst.after");
        bus.pkt_ready = 1'b1;
        send_byte(8'h66);
        check("rst.fresh_busy", 32'(busy), 32'd1);
        send_byte(8'h77);
        check_head("rst.fresh", 8'h66, 8'h77, 1'b0);
        tick();
        check("rst.fresh_popped", 32'(bus.pkt_valid), 32'd0);

        // FIFO full, a pop coincides with the completing byte: no drop.
        bus.pkt_ready = 1'b0;
        send_byte(8'h11); send_byte(8'h12);
        send_byte(8'h13); send_byte(8'h14);
        send_byte(8'h15);
        bus.pkt_ready = 1'b1;
        send_byte(8'h16);
        check("full_pop.drops", 32'(drop_count), 32'd0);
        check("full_pop.overflow", 32'(overflow), 32'd0);
        check_head("full_pop.head0", 8'h13, 8'h14, 1'b0);
        tick();
        check_head("full_pop.head1", 8'h15, 8'h16, 1'b0);
        tick();
        check("full_pop.drained", 32'(bus.pkt_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ext_packet_assembler.md
Name: ext_packet_assembler

Overview:
Sits directly downstream of the external-sensor uart_top receiver (o_rx_dv/o_rx_byte) and upstream of the top-level transmit FSM.
- Groups raw received bytes into sensor response packets: two-byte packet, or single-byte packet on inter-byte timeout.
- Buffers completed packets in a small FIFO.
- Presents them on a valid/ready interface, so the transmit FSM never has to catch a one-cycle strobe.

Parameters:
CLK_FREQ, 25_000_000, system clock frequency in Hz
TIMEOUT_US, 1000, inter-byte timeout in microseconds; TIMEOUT_CYCLES = (CLK_FREQ/1_000_000)*TIMEOUT_US (25_000 at defaults)
FIFO_DEPTH, 2, packet buffer entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_dv  in  1  one-cycle strobe: received byte valid
rx_byte  in  8  received byte
pkt_ready  in  1  consumer accepts head packet
pkt_valid  out  1  FIFO non-empty; head packet fields valid
pkt_byte1  out  8  head packet first byte (header)
pkt_byte2  out  8  head packet measurement byte
pkt_single  out  1  head packet closed by timeout (one byte received)
busy  out  1  assembler not in S_IDLE
overflow  out  1  sticky: a completed packet was dropped
drop_count  out  8  dropped-packet count, saturates at 8'hFF

Behaviour:
Reset and clock:
- One clock. Reset is synchronous and active-high: clk, rst.
- On rst: state=S_IDLE, timeout counter=0, FIFO empty.
- On rst, all outputs are 0: pkt_valid=0, pkt_byte1=0, pkt_byte2=0, pkt_single=0, busy=0, overflow=0, drop_count=0.
- rst asserted mid-packet discards the partial packet and all buffered packets. No push occurs in the reset cycle.

Assembler FSM:
- S_IDLE: on rx_dv, latch b1=rx_byte, clear counter, go to S_WAIT_B2.
- S_WAIT_B2, rx_dv=1: form {b1, rx_byte, single=0}, push, go to S_IDLE.
- S_WAIT_B2, no rx_dv, counter==TIMEOUT_CYCLES-1: form {b1, b1, single=1}, push, go to S_IDLE. The measurement byte duplicates byte1.
- S_WAIT_B2, otherwise: counter increments.
- rx_dv in the same cycle as the timeout: the byte wins and becomes byte2 (single=0).
- Counter width is $clog2(TIMEOUT_CYCLES). The counter is cleared on every entry to S_WAIT_B2.
- Push latency: the packet appears on pkt_valid/pkt_* in the cycle after the completing rx_dv or timeout cycle.

FIFO and handshake:
- pkt_valid = !empty. pkt_* are driven from the head entry, registered storage.
- Pop occurs when pkt_valid && pkt_ready. pkt_ready while empty has no effect.
- Head fields are stable while pkt_valid=1 and no pop occurs.
- Push while full and no pop: the new packet is dropped, overflow is set, and drop_count increments, saturating at 255. Existing entries are unchanged.
- Push while full with a pop in the same cycle: both occur, with no drop.
- Push while empty: the packet becomes visible next cycle. There is no bypass path.
- Read and write pointers wrap modulo FIFO_DEPTH. An extra pointer bit distinguishes full from empty.

Status:
- busy = (state != S_IDLE).
- overflow and drop_count are cleared only by rst.

Decomposition:
Package ext_pkt_pkg contains:
- typedef struct packed {logic [7:0] byte1; logic [7:0] byte2; logic single;} ext_pkt_t
- typedef enum logic {S_IDLE, S_WAIT_B2} asm_state_t
- function timeout_cycles(clk_freq, timeout_us)
Sub-module pkt_fifo #(DEPTH, type T=ext_pkt_t):
- synchronous FIFO with push/pop, full/empty
- simultaneous push+pop when full is legal

Test Plan:
- rx 8'h21 then 8'h5A 100 cycles later, pkt_ready=1 -> one cycle of pkt_valid, byte1=8'h21, byte2=8'h5A, single=0; busy is 1 from the cycle after the first byte until the cycle after the second.
- rx 8'h33 only, no second byte -> after exactly 25_000 cycles in S_WAIT_B2, packet {8'h33, 8'h33, single=1} is valid on the next cycle.
- rx 8'h44, then second byte 8'h07 arriving exactly on the timeout cycle -> {8'h44, 8'h07, single=0}; no single-byte packet is produced.
- pkt_ready=0, send three 2-byte packets {01,02},{03,04},{05,06} -> FIFO holds the first two, overflow=1, drop_count=1; raising pkt_ready pops {01,02} then {03,04}, then pkt_valid=0.
- FIFO full with pkt_ready=1 on the same cycle a new packet completes -> no drop, count stays 0, order preserved.
- rst pulse one cycle after the first byte of a packet, with one packet buffered -> all outputs 0, FIFO empty; a subsequent byte starts a fresh packet.
